dmem_pipe: RTL and testbench
============================

// Module: dmem_pipe
// PURPOSE
//  Parametrised data memory with a valid/ready request port and a fixed-latency response.
//  Successor to the single-cycle combinational dmem: adds configurable read/write latency,
//  RV32 byte/half/word sizing with sign/zero extension, and misaligned/out-of-range detection.
//  Sits between the pipeline MEM stage and storage; the core stalls while req_ready is low.
// PARAMETERS
//  ADDR_W     18      word-address width; array holds 2**ADDR_W words
//  DATA_W     32      word width; fixed at 32 for RV32
//  LATENCY    1       cycles from accept edge to resp_valid; legal range 1..8
//  INIT_FILE  ""      $readmemh image loaded at elaboration when non-empty
//  TOHOST_ADDR 32'hFFFF_FFF0  byte address of the tohost register (macro builds only)
// PORTS
//  clk          in   1       clock, rising edge
//  reset        in   1       synchronous, active-high
//  req_valid    in   1       request present
//  req_ready    out  1       block can accept; high only in IDLE
//  req_we       in   1       1 = store, 0 = load
//  req_size     in   3       funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  req_addr     in   32      byte address
//  req_wdata    in   32      store data, right-aligned
//  resp_valid   out  1       one-cycle pulse; no backpressure
//  resp_rdata   out  32      extended load data; 0 for stores and errors
//  resp_err     out  1       misaligned, out-of-range, or illegal size
//  tohost_valid out  1       (DMEM_TOHOST_EN only) one-cycle pulse on tohost store
//  tohost_data  out  32      (DMEM_TOHOST_EN only) last tohost value
// BEHAVIOUR
//  - Reset values: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, tohost_valid=0,
//    tohost_data=0. The array is never cleared by reset.
//  - FSM states:
//    - IDLE -> WAIT on req_valid (accept edge). Request fields are latched.
//    - WAIT counts LATENCY-1 cycles.
//    - RESP drives resp_valid for exactly 1 cycle, then returns to IDLE.
//    - If LATENCY==1, IDLE goes directly to RESP.
//    - resp_valid is high in cycle accept+LATENCY.
//    - req_ready=0 in WAIT and RESP: exactly one request is outstanding; no back-to-back accept.
//  - Stores:
//    - Commit at the accept edge via byte enables.
//    - Size B uses lane addr[1:0], H uses lanes {addr[1],0}/+1, W uses all four lanes.
//    - Loads issued after a store therefore see the new data.
//  - Loads:
//    - The word is read at the accept edge and held for the whole latency.
//    - Lane select plus extension: B/H sign-extend; BU/HU zero-extend.
//  - Errors: no array write, resp_rdata=0, resp_err=1. Causes:
//    - H/HU with addr[0]=1.
//    - W with addr[1:0]!=0.
//    - BU/HU store.
//    - size in {011,110,111}.
//    - addr[31:ADDR_W+2]!=0.
//  - Error responses keep the normal latency.
//  - Reset asserted in WAIT/RESP: the transaction is aborted and no resp_valid is produced.
//    A store already committed stays committed.
//  - req_* changes while req_ready=0 are ignored.
//  - The counter width is clog2(8). The counter clears on every accept, so there is no wrap issue.
// CONFIGURATION
//  `DMEM_TOHOST_EN defined:
//   - The tohost ports exist.
//   - A W store to TOHOST_ADDR sets tohost_data and pulses tohost_valid at the accept edge
//     + 1 cycle. The array is not written; resp_err=0.
//   - A load from TOHOST_ADDR returns tohost_data.
//   - A non-W access to TOHOST_ADDR gives resp_err=1.
//  `DMEM_TOHOST_EN undefined:
//   - The ports are absent.
//   - TOHOST_ADDR is an ordinary address, out-of-range when ADDR_W<30, so it gives resp_err=1.
// STRUCTURE
//  - riscv_mem_pkg holds:
//    - mem_size_e (funct3 size encodings).
//    - dmem_state_e {IDLE,WAIT,RESP}.
//    - The lane byte-enable function.
//  - Sub-module dmem_lane (combinational):
//    - Store path: size + addr[1:0] + wdata -> byte enables + shifted data.
//    - Load path: word + size + addr[1:0] -> extended rdata.
//    - Also produces the misalign/illegal flags.
//  - dmem_pipe holds the FSM, latency counter, latched request, array and tohost register.
// TESTING
//  - LATENCY=3: SW 0x1000 = 0xDEADBEEF, then LW 0x1000.
//    Expect resp_valid 3 cycles after each accept, rdata=0xDEADBEEF, err=0.
//    req_ready is low for 3 cycles.
//  - After the store above:
//    - LB 0x1003 -> 0xFFFFFFDE.
//    - LBU 0x1003 -> 0x000000DE.
//    - LH 0x1002 -> 0xFFFFDEAD.
//    - LHU 0x1000 -> 0x0000BEEF.
//  - SB 0x1001 = 0x55, then LW 0x1000 -> 0xDEAD55EF.
//  - Errors:
//    - LW 0x1002 -> err=1, rdata=0.
//    - SH 0x1001 -> err=1, then LW 0x1000 unchanged.
//    - size=011 -> err=1.
//    - addr 0x0100_0000 with ADDR_W=18 -> err=1.
//  - Reset mid-operation: accept LW with LATENCY=4, assert reset in cycle 2.
//    Expect no resp_valid, req_ready=1 the cycle after reset drops.
//    A following LW completes normally.
//  - With DMEM_TOHOST_EN: SW TOHOST_ADDR = 0x1 -> tohost_valid pulses once, tohost_data=1,
//    array word unchanged.
//    Without DMEM_TOHOST_EN: the same store gives err=1.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// Shared types for the pipelined data memory: RV32 access sizes, FSM states and
// the lane byte-enable decode.
package riscv_mem_pkg;

    localparam int unsigned CNT_W = 3;  // enough for LATENCY up to 8

    typedef enum logic [2:0] {
        SizeB  = 3'b000,
        SizeH  = 3'b001,
        SizeW  = 3'b010,
        SizeBu = 3'b100,
        SizeHu = 3'b101
    } mem_size_e;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } dmem_state_e;

    function automatic logic [3:0] lane_be(input logic [2:0] size, input logic [1:0] addr_lo);
        logic [3:0] be;
        case (size)
            SizeB, SizeBu: be = 4'b0001 << addr_lo;
            SizeH, SizeHu: be = addr_lo[1] ? 4'b1100 : 4'b0011;
            SizeW:         be = 4'b1111;
            default:       be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/dmem_pipe_if.sv
// Request/response bundle between the MEM stage (master) and dmem_pipe (slave).
// The tohost signals exist only when DMEM_TOHOST_EN is defined.
interface dmem_pipe_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
`ifdef DMEM_TOHOST_EN
    logic        tohost_valid;
    logic [31:0] tohost_data;
`endif

    modport master (
        output req_valid, req_we, req_size, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
`ifdef DMEM_TOHOST_EN
        , input tohost_valid, tohost_data
`endif
    );

    modport slave (
        input  req_valid, req_we, req_size, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
`ifdef DMEM_TOHOST_EN
        , output tohost_valid, tohost_data
`endif
    );
endinterface

// File: rtl/dmem_pipe_lane.sv
// Combinational lane logic: store byte enables and alignment, load lane select with
// sign/zero extension, plus misalignment and illegal-size detection.
module dmem_lane
    import riscv_mem_pkg::*;
(
    input  logic [2:0]  i_size,
    input  logic [1:0]  i_addr_lo,
    input  logic        i_we,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_word,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata,
    output logic        o_misalign,
    output logic        o_illegal
);
    logic [31:0] w_sh;

    assign o_be    = lane_be(i_size, i_addr_lo);
    assign o_wdata = i_wdata << {i_addr_lo, 3'b000};
    assign w_sh    = i_word >> {i_addr_lo, 3'b000};

    always_comb begin
        o_rdata = 32'd0;
        case (i_size)
            SizeB:   o_rdata = {{24{w_sh[7]}}, w_sh[7:0]};
            SizeBu:  o_rdata = {24'd0, w_sh[7:0]};
            SizeH:   o_rdata = {{16{w_sh[15]}}, w_sh[15:0]};
            SizeHu:  o_rdata = {16'd0, w_sh[15:0]};
            SizeW:   o_rdata = i_word;
            default: o_rdata = 32'd0;
        endcase
    end

    assign o_misalign = ((i_size[1:0] == 2'b01) && i_addr_lo[0]) ||
                        ((i_size == SizeW) && (i_addr_lo != 2'b00));
    // Unsigned sizes are load-only.
    assign o_illegal  = (i_size == 3'b011) || (i_size == 3'b110) || (i_size == 3'b111) ||
                        (i_we && i_size[2]);

endmodule

// File: rtl/dmem_pipe.sv
// Fixed-latency data memory with a valid/ready request port and one-cycle response pulse.
// Define DMEM_TOHOST_EN to add the memory-mapped tohost register.
module dmem_pipe
    import riscv_mem_pkg::*;
#(
    parameter int unsigned ADDR_W      = 18,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned LATENCY     = 1,
    parameter string       INIT_FILE   = ""
`ifdef DMEM_TOHOST_EN
    ,
    parameter logic [31:0] TOHOST_ADDR = 32'hFFFF_FFF0
`endif
) (
    input logic        clk,
    input logic        reset,
    dmem_pipe_if.slave bus
);
    localparam logic [CNT_W-1:0] CntLast = (LATENCY > 1) ? CNT_W'(LATENCY - 2) : '0;

    logic [DATA_W-1:0] r_mem [2**ADDR_W];

    dmem_state_e       r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [31:0]       r_rdata;
    logic              r_err;
    logic              r_req_ready;
    logic              r_resp_valid;
    logic [31:0]       r_resp_rdata;
    logic              r_resp_err;

    logic [ADDR_W-1:0] w_idx;
    logic [31:0]       w_word;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata_sh;
    logic [31:0]       w_ld_data;
    logic              w_misalign;
    logic              w_illegal;
    logic              w_oor;
    logic              w_err;
    logic              w_accept;
    logic              w_mem_we;

    assign w_idx    = bus.req_addr[ADDR_W+1:2];
    assign w_oor    = (bus.req_addr >> (ADDR_W + 2)) != 32'd0;
    assign w_accept = (r_state == StIdle) && bus.req_valid && !reset;

`ifdef DMEM_TOHOST_EN
    logic        r_tohost_valid;
    logic [31:0] r_tohost_data;
    logic        w_is_tohost;

    assign w_is_tohost = (bus.req_addr == TOHOST_ADDR);
    assign w_word      = w_is_tohost ? r_tohost_data : r_mem[w_idx];
    // tohost overrides the range check but only accepts word accesses.
    assign w_err       = w_is_tohost ? (bus.req_size != SizeW)
                                     : (w_misalign || w_illegal || w_oor);
    assign w_mem_we    = w_accept && bus.req_we && !w_err && !w_is_tohost;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tohost_valid <= 1'b0;
            r_tohost_data  <= 32'd0;
        end else begin
            r_tohost_valid <= 1'b0;
            if (w_accept && w_is_tohost && bus.req_we && !w_err) begin
                r_tohost_valid <= 1'b1;
                r_tohost_data  <= bus.req_wdata;
            end
        end
    end

    assign bus.tohost_valid = r_tohost_valid;
    assign bus.tohost_data  = r_tohost_data;
`else
    assign w_word   = r_mem[w_idx];
    assign w_err    = w_misalign || w_illegal || w_oor;
    assign w_mem_we = w_accept && bus.req_we && !w_err;
`endif

    dmem_lane u_lane (
        .i_size     (bus.req_size),
        .i_addr_lo  (bus.req_addr[1:0]),
        .i_we       (bus.req_we),
        .i_wdata    (bus.req_wdata),
        .i_word     (w_word),
        .o_be       (w_be),
        .o_wdata    (w_wdata_sh),
        .o_rdata    (w_ld_data),
        .o_misalign (w_misalign),
        .o_illegal  (w_illegal)
    );

    // Stores commit at the accept edge; the array is never cleared.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_wdata_sh[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= StIdle;
            r_cnt        <= '0;
            r_rdata      <= 32'd0;
            r_err        <= 1'b0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'd0;
            r_resp_err   <= 1'b0;
        end else begin
            r_resp_valid <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (bus.req_valid) begin
                        r_rdata     <= (w_err || bus.req_we) ? 32'd0 : w_ld_data;
                        r_err       <= w_err;
                        r_cnt       <= '0;
                        r_req_ready <= 1'b0;
                        if (LATENCY == 1) begin
                            r_state      <= StResp;
                            r_resp_valid <= 1'b1;
                            r_resp_rdata <= (w_err || bus.req_we) ? 32'd0 : w_ld_data;
                            r_resp_err   <= w_err;
                        end else begin
                            r_state <= StWait;
                        end
                    end
                end
                StWait: begin
                    if (r_cnt == CntLast) begin
                        r_state      <= StResp;
                        r_resp_valid <= 1'b1;
                        r_resp_rdata <= r_rdata;
                        r_resp_err   <= r_err;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                StResp: begin
                    r_state     <= StIdle;
                    r_req_ready <= 1'b1;
                end
                default: begin
                    r_state     <= StIdle;
                    r_req_ready <= 1'b1;
                end
            endcase
        end
    end

    assign bus.req_ready  = r_req_ready;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_rdata = r_resp_rdata;
    assign bus.resp_err   = r_resp_err;

endmodule

// File: tb/tb_dmem_pipe.sv
// Scoreboard bench for dmem_pipe (LATENCY=3): directed RV32 sizing/error cases, a
// mid-transaction reset, and randomized traffic against a byte-level reference model.
module tb_dmem_pipe;

    localparam int unsigned LAT     = 3;
    localparam int unsigned AW      = 18;
    localparam longint      MEM_B   = 64'd4 << AW;
    localparam logic [31:0] TH_ADDR = 32'hFFFF_FFF0;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int unsigned due;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    int unsigned cyc = 0;
    int          n_vec = 0;
    int          n_bad = 0;
    exp_t        sbq[$];
    logic [31:0] mdl [int unsigned];
    logic [31:0] th_data = 32'd0;
    int          th_pulses_exp = 0;
    int          th_pulses = 0;

    dmem_pipe_if bus ();

    dmem_pipe #(
        .ADDR_W  (AW),
        .LATENCY (LAT)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
        end
    endfunction

    // Reference: byte-addressed little-endian memory, sizes as byte counts.
    function automatic void model(input logic we, input logic [2:0] sz, input logic [31:0] addr,
                                  input logic [31:0] wd, output logic err, output logic [31:0] rd);
        int unsigned n;
        int unsigned off;
        logic        sgn;
        logic        legal;
        logic [31:0] word;
        logic [31:0] v;
        legal = 1'b1;
        n     = 1;
        sgn   = 1'b0;
        case (sz)
            3'd0: begin n = 1; sgn = 1'b1; end
            3'd1: begin n = 2; sgn = 1'b1; end
            3'd2: begin n = 4; sgn = 1'b0; end
            3'd4: begin n = 1; sgn = 1'b0; end
            3'd5: begin n = 2; sgn = 1'b0; end
            default: legal = 1'b0;
        endcase
        rd = 32'd0;
`ifdef DMEM_TOHOST_EN
        if (addr == TH_ADDR) begin
            err = (sz != 3'd2);
            if (!err) begin
                if (we) begin
                    th_data = wd;
                    th_pulses_exp++;
                end else begin
                    rd = th_data;
                end
            end
            return;
        end
`endif
        err = !legal || ((addr % n) != 0) || (we && (sz >= 3'd4)) || (longint'(addr) >= MEM_B);
        if (err) return;
        off  = addr % 4;
        word = mdl.exists(addr / 4) ? mdl[addr / 4] : 32'hxxxx_xxxx;
        if (we) begin
            for (int k = 0; k < int'(n); k++) word[8*(off+k) +: 8] = wd[8*k +: 8];
            mdl[addr / 4] = word;
        end else begin
            v = 32'd0;
            for (int k = 0; k < int'(n); k++) v[8*k +: 8] = word[8*(off+k) +: 8];
            if (sgn && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
            rd = v;
        end
    endfunction

    task automatic issue(input string nm, input logic we, input logic [2:0] sz,
                         input logic [31:0] addr, input logic [31:0] wd);
        exp_t e;
        int   guard;
        int   low;
        guard = 0;
        @(negedge clk);
        while (!bus.req_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.req_ready) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s_ready_timeout: got req_ready=0, want 1", nm);
            return;
        end
        model(we, sz, addr, wd, e.err, e.rd);
        e.due  = cyc + LAT;
        e.name = nm;
        sbq.push_back(e);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_size  = sz;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        @(negedge clk);
        // While busy, present junk stores that must be ignored.
        low = 0;
        while (!bus.req_ready && low < 20) begin
            bus.req_valid = 1'b1;
            bus.req_we    = 1'b1;
            bus.req_size  = 3'd2;
            bus.req_addr  = 32'h0000_1000 + {$urandom_range(0, 3), 2'b00};
            bus.req_wdata = $urandom;
            @(negedge clk);
            low++;
        end
        bus.req_valid = 1'b0;
        check({nm, "_ready_low"}, low, LAT);
    endtask

    // Monitor: pops the scoreboard whenever a response appears.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && bus.resp_valid) begin
                if (sbq.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_resp: got resp_valid=1 at cycle %0d, want 0", cyc);
                end else begin
                    e = sbq.pop_front();
                    check({e.name, "_rdata"}, bus.resp_rdata, e.rd);
                    check({e.name, "_err"}, bus.resp_err, e.err);
                    check({e.name, "_lat"}, cyc, e.due);
                end
            end
`ifdef DMEM_TOHOST_EN
            if (!reset && bus.tohost_valid) th_pulses++;
`endif
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        logic [31:0] a;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_size  = 3'd0;
        bus.req_addr  = 32'd0;
        bus.req_wdata = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_ready", bus.req_ready, 1'b1);
        check("rst_valid", bus.resp_valid, 1'b0);
        check("rst_rdata", bus.resp_rdata, 32'd0);
        check("rst_err", bus.resp_err, 1'b0);
`ifdef DMEM_TOHOST_EN
        check("rst_th_valid", bus.tohost_valid, 1'b0);
        check("rst_th_data", bus.tohost_data, 32'd0);
`endif

        issue("sw_1000", 1'b1, 3'd2, 32'h1000, 32'hDEAD_BEEF);
        issue("lw_1000", 1'b0, 3'd2, 32'h1000, 32'd0);
        issue("lb_1003", 1'b0, 3'd0, 32'h1003, 32'd0);
        issue("lbu_1003", 1'b0, 3'd4, 32'h1003, 32'd0);
        issue("lh_1002", 1'b0, 3'd1, 32'h1002, 32'd0);
        issue("lhu_1000", 1'b0, 3'd5, 32'h1000, 32'd0);
        issue("sb_1001", 1'b1, 3'd0, 32'h1001, 32'h0000_0055);
        issue("lw_after_sb", 1'b0, 3'd2, 32'h1000, 32'd0);
        issue("lw_misal", 1'b0, 3'd2, 32'h1002, 32'd0);
        issue("sh_misal", 1'b1, 3'd1, 32'h1001, 32'h0000_AAAA);
        issue("lw_after_sh", 1'b0, 3'd2, 32'h1000, 32'd0);
        issue("size_011", 1'b0, 3'd3, 32'h1000, 32'd0);
        issue("oor_load", 1'b0, 3'd2, 32'h0100_0000, 32'd0);
        issue("sbu_store", 1'b1, 3'd4, 32'h1000, 32'h0000_0011);
        issue("sw_alias", 1'b1, 3'd2, 32'h000F_FFF0, 32'h1234_5678);
        issue("sw_tohost", 1'b1, 3'd2, TH_ADDR, 32'h0000_0001);
        issue("lw_alias", 1'b0, 3'd2, 32'h000F_FFF0, 32'd0);
        issue("lw_tohost", 1'b0, 3'd2, TH_ADDR, 32'd0);
        issue("lb_tohost", 1'b0, 3'd0, TH_ADDR, 32'd0);

        // Reset two cycles after accepting a load: no response may follow.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_size  = 3'd2;
        bus.req_addr  = 32'h1000;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_no_resp", bus.resp_valid, 1'b0);
        @(negedge clk);
        check("midrst_ready", bus.req_ready, 1'b1);
        check("midrst_no_resp2", bus.resp_valid, 1'b0);
        issue("lw_after_rst", 1'b0, 3'd2, 32'h1000, 32'd0);

        for (int i = 0; i < 64; i++) begin
            issue("init", 1'b1, 3'd2, 32'h2000 + 32'(4 * i), $urandom);
        end
        for (int i = 0; i < 200; i++) begin
            a = 32'h2000 + 32'($urandom_range(0, 255));
            if ($urandom_range(0, 15) == 0) a = a | 32'h0400_0000;
            issue("rand", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom);
        end

        guard = 0;
        while (sbq.size() != 0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("drain_left", sbq.size(), 0);
`ifdef DMEM_TOHOST_EN
        check("th_pulses", th_pulses, th_pulses_exp);
        check("th_data", bus.tohost_data, th_data);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
